// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the GCD dispatch block: the dispatcher FSM state
// encoding, the operand width and the default RUN timeout length.
package gcd_pkg;

  localparam int OP_W        = 32;
  localparam int PAIR_W      = 2 * OP_W;
  localparam int TMO_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CAPT,
    S_OUT
  } state_t;

endpackage

// File: rtl/gcd_opq.sv
// gcd_opq
// Synchronous FIFO holding queued operand pairs, with an occupancy count.
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset (empties the queue)
//   i_push       - write i_data this cycle (ignored when full)
//   i_data       - packed operand pair {opa, opb}
//   i_pop        - drop the head entry this cycle (ignored when empty)
//   o_data       - current head entry (valid while o_count != 0)
//   o_full       - occupancy equals DEPTH
//   o_count      - current occupancy, 0..DEPTH
module gcd_opq #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && (r_count != '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gcd_dispatch.sv
// gcd_dispatch
// Queues operand pairs and feeds them one at a time to an external GCD core,
// returning each result (or a timeout error) through a valid/ready port.
// Pairs with a zero operand bypass the core entirely.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   in_valid/in_ready      - operand pair handshake, in_opa/in_opb operands
//   gcd_opa/gcd_opb        - registered operands to the GCD core
//   gcd_start              - registered start level to the GCD core
//   gcd_result/gcd_done    - result and completion from the GCD core
//   out_valid/out_ready    - result handshake, out_result value, out_err timeout flag
//   count                  - operand queue occupancy
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_opa,
  input  logic [OP_W-1:0]        in_opb,
  output logic [OP_W-1:0]        gcd_opa,
  output logic [OP_W-1:0]        gcd_opb,
  output logic                   gcd_start,
  input  logic [OP_W-1:0]        gcd_result,
  input  logic                   gcd_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_result,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  // RUN-cycle index of the last cycle before timeout, and the first RUN
  // cycle index on which gcd_done is honoured.
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYC - 1);
  localparam logic [31:0] DONE_MIN = 32'd2;

  state_t               r_state;
  logic [OP_W-1:0]      r_gcdOpa;
  logic [OP_W-1:0]      r_gcdOpb;
  logic                 r_gcdStart;
  logic                 r_outValid;
  logic [OP_W-1:0]      r_outResult;
  logic                 r_outErr;
  logic [31:0]          r_tmoCnt;

  logic                  w_full;
  logic                  w_pop;
  logic [PAIR_W-1:0]     w_head;
  logic [OP_W-1:0]       w_headA;
  logic [OP_W-1:0]       w_headB;
  logic [$clog2(DEPTH):0] w_count;

  // in_ready gives no credit for a same-cycle pop and is forced low while
  // reset is held.
  assign in_ready = resetn && !w_full;
  assign w_pop    = (r_state == S_IDLE) && (w_count != '0);
  assign w_headA  = w_head[PAIR_W-1:OP_W];
  assign w_headB  = w_head[OP_W-1:0];

  gcd_opq #(
    .DEPTH (DEPTH),
    .W     (PAIR_W)
  ) u_opq (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (in_valid && in_ready),
    .i_data  ({in_opa, in_opb}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Dispatcher FSM. All core-facing and result outputs are registered here.
  // The timeout counter indexes RUN cycles from 0; done is ignored on
  // indices 0 and 1, and a done on the final index beats the timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_gcdOpa    <= '0;
      r_gcdOpb    <= '0;
      r_gcdStart  <= 1'b0;
      r_outValid  <= 1'b0;
      r_outResult <= '0;
      r_outErr    <= 1'b0;
      r_tmoCnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if ((w_headA == '0) || (w_headB == '0)) begin
              r_outResult <= w_headA | w_headB;
              r_outErr    <= 1'b0;
              r_outValid  <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_gcdOpa <= w_headA;
              r_gcdOpb <= w_headB;
              r_state  <= S_ARM;
            end
          end
        end
        S_ARM: begin
          r_gcdStart <= 1'b1;
          r_tmoCnt   <= '0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if ((r_tmoCnt >= DONE_MIN) && gcd_done) begin
            r_state <= S_CAPT;
          end else if (r_tmoCnt == TMO_LAST) begin
            r_gcdStart  <= 1'b0;
            r_outResult <= '0;
            r_outErr    <= 1'b1;
            r_outValid  <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_tmoCnt <= r_tmoCnt + 32'd1;
          end
        end
        S_CAPT: begin
          r_gcdStart  <= 1'b0;
          r_outResult <= gcd_result;
          r_outErr    <= 1'b0;
          r_outValid  <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gcd_opa    = r_gcdOpa;
  assign gcd_opb    = r_gcdOpb;
  assign gcd_start  = r_gcdStart;
  assign out_valid  = r_outValid;
  assign out_result = r_outResult;
  assign out_err    = r_outErr;
  assign count      = w_count;

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch
// Self-checking bench for gcd_dispatch. Contains a behavioural GCD core
// (optionally a stub that never completes) and a scoreboard of expected
// results computed with plain Euclid arithmetic.
module tb_gcd_dispatch;
  import gcd_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_opa = '0;
  logic [OP_W-1:0]   in_opb = '0;
  logic [OP_W-1:0]   gcd_opa;
  logic [OP_W-1:0]   gcd_opb;
  logic              gcd_start;
  logic [OP_W-1:0]   gcd_result = '0;
  logic              gcd_done = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OP_W-1:0]   out_result;
  logic              out_err;
  logic [$clog2(DEPTH):0] count;

  int nCompared = 0;
  int nMismatched = 0;

  logic [OP_W-1:0] expA[$];
  logic [OP_W-1:0] expB[$];
  logic [OP_W-1:0] expRes[$];
  bit              expErr[$];
  logic [OP_W-1:0] resultLog[$];
  bit              errLog[$];

  bit stubMode = 0;
  int coreLat = 0;
  int coreCnt = 0;
  int startHigh = 0;
  int startRises = 0;

  gcd_dispatch #(
    .DEPTH   (DEPTH),
    .TMO_CYC (TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .gcd_opa    (gcd_opa),
    .gcd_opb    (gcd_opb),
    .gcd_start  (gcd_start),
    .gcd_result (gcd_result),
    .gcd_done   (gcd_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [OP_W-1:0] gcdRef(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [OP_W-1:0] x = a;
    logic [OP_W-1:0] y = b;
    logic [OP_W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Push one pair when the queue has room and record what it must produce.
  task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    int waitCyc = 0;
    @(negedge clk);
    while (!in_ready && waitCyc < 200) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!in_ready) begin
      checkOutput("pushReady", in_ready, 1);
    end else begin
      in_valid = 1'b1;
      in_opa   = a;
      in_opb   = b;
      expA.push_back(a);
      expB.push_back(b);
      if (stubMode && a != '0 && b != '0) begin
        expRes.push_back('0);
        expErr.push_back(1'b1);
      end else begin
        expRes.push_back(gcdRef(a, b));
        expErr.push_back(1'b0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Cycles from the push edge until out_valid is seen (1 = cycle after push).
  task automatic measureLatency(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat >= 500) break;
      lat++;
    end
  endtask

  task automatic waitDrain(input string name);
    int cyc = 0;
    while (expRes.size() != 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(name, expRes.size(), 0);
  endtask

  // Behavioural GCD core: answers coreLat cycles after seeing start, holds
  // the result while start stays high; the stub never answers.
  initial begin
    forever begin
      @(negedge clk);
      if (!gcd_start) begin
        coreCnt  = 0;
        gcd_done = 1'b0;
      end else begin
        if (!stubMode && coreCnt >= coreLat) begin
          gcd_result = gcdRef(gcd_opa, gcd_opb);
          gcd_done   = 1'b1;
        end
        coreCnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (gcd_start === 1'b1) startHigh++;
  end

  always @(posedge gcd_start) startRises++;

  // Per-cycle scoreboard comparison against the model queues.
  always @(negedge clk) begin
    if (resetn) begin
      checkOutput("inReadyRule", in_ready, (count < DEPTH));
      if (gcd_start) begin
        if (expA.size() == 0) begin
          checkOutput("startNoWork", gcd_start, 0);
        end else begin
          checkOutput("gcdOpa", gcd_opa, expA[0]);
          checkOutput("gcdOpb", gcd_opb, expB[0]);
        end
      end
      if (out_valid) begin
        if (expRes.size() == 0) begin
          checkOutput("spuriousValid", out_valid, 0);
        end else begin
          checkOutput("outResult", out_result, expRes[0]);
          checkOutput("outErr", out_err, expErr[0]);
          if (out_ready) begin
            resultLog.push_back(out_result);
            errLog.push_back(out_err);
            void'(expA.pop_front());
            void'(expB.pop_front());
            void'(expRes.pop_front());
            void'(expErr.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int waitCyc;
    int bpList[5];
    bpList = '{2, 72, 19, 14, 11};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstStart", gcd_start, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstResult", out_result, 0);
    checkOutput("rstErr", out_err, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstOpa", gcd_opa, 0);
    checkOutput("rstOpb", gcd_opb, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("relInReady", in_ready, 1);

    // Zero-operand bypass
    startRises = 0;
    resultLog.delete();
    applyStimulus(32'd0, 32'd45);
    measureLatency(lat);
    checkOutput("bypassLat45", lat, 2);
    repeat (3) @(posedge clk);
    applyStimulus(32'd0, 32'd0);
    measureLatency(lat);
    checkOutput("bypassLat0", lat, 2);
    waitDrain("drainBypass");
    checkOutput("bypassStart", startRises, 0);
    checkOutput("bypassCount", resultLog.size(), 2);
    if (resultLog.size() == 2) begin
      checkOutput("bypassRes45", resultLog[0], 45);
      checkOutput("bypassRes0", resultLog[1], 0);
    end

    // Normal path, core answers immediately: done masked for 2 RUN cycles
    repeat (2) @(posedge clk);
    resultLog.delete();
    coreLat = 0;
    startHigh = 0;
    startRises = 0;
    applyStimulus(32'd102, 32'd12);
    measureLatency(lat);
    checkOutput("runLat", lat, 7);
    waitDrain("drainRun");
    checkOutput("runStartHigh", startHigh, 4);
    checkOutput("runStartRises", startRises, 1);
    if (resultLog.size() == 1) checkOutput("runRes6", resultLog[0], 6);
    else checkOutput("runResCount", resultLog.size(), 1);

    // Normal path, slower core
    repeat (2) @(posedge clk);
    resultLog.delete();
    coreLat = 4;
    startHigh = 0;
    applyStimulus(32'd42, 32'd56);
    measureLatency(lat);
    checkOutput("slowLat", lat, 9);
    waitDrain("drainSlow");
    checkOutput("slowStartHigh", startHigh, 6);
    if (resultLog.size() == 1) checkOutput("slowRes14", resultLog[0], 14);
    else checkOutput("slowResCount", resultLog.size(), 1);

    // Backpressure and queue full
    coreLat = 0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    resultLog.delete();
    applyStimulus(32'd18190, 32'd13082);
    applyStimulus(32'd23040, 32'd1944);
    applyStimulus(32'd51167, 32'd266);
    applyStimulus(32'd93842, 32'd82082);
    applyStimulus(32'd13211, 32'd27632);
    repeat (10) @(negedge clk);
    checkOutput("fullCount", count, DEPTH);
    checkOutput("fullInReady", in_ready, 0);
    checkOutput("fullValid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain("drainFull");
    checkOutput("fullResCount", resultLog.size(), 5);
    if (resultLog.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("fullOrder%0d", i), resultLog[i], bpList[i]);
      end
    end

    // Timeout with a core that never completes, then a normal pair
    repeat (2) @(posedge clk);
    resultLog.delete();
    errLog.delete();
    stubMode = 1;
    startHigh = 0;
    applyStimulus(32'd7, 32'd3);
    measureLatency(lat);
    checkOutput("tmoLat", lat, TMO + 3);
    checkOutput("tmoStartHigh", startHigh, TMO);
    waitDrain("drainTmo");
    if (resultLog.size() == 1) begin
      checkOutput("tmoRes", resultLog[0], 0);
      checkOutput("tmoErr", errLog[0], 1);
    end else begin
      checkOutput("tmoResCount", resultLog.size(), 1);
    end
    stubMode = 0;
    resultLog.delete();
    applyStimulus(32'd9, 32'd6);
    measureLatency(lat);
    checkOutput("afterTmoLat", lat, 7);
    waitDrain("drainAfterTmo");
    if (resultLog.size() == 1) checkOutput("afterTmoRes3", resultLog[0], 3);
    else checkOutput("afterTmoCount", resultLog.size(), 1);

    // Reset in the middle of RUN with pairs queued
    coreLat = 30;
    resultLog.delete();
    applyStimulus(32'd8, 32'd4);
    applyStimulus(32'd10, 32'd4);
    applyStimulus(32'd12, 32'd8);
    applyStimulus(32'd15, 32'd5);
    waitCyc = 0;
    @(negedge clk);
    while (!(count == 3 && gcd_start) && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("preRstRun", (count == 3 && gcd_start), 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midRstStart", gcd_start, 0);
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstCount", count, 0);
    checkOutput("midRstInReady", in_ready, 0);
    expA.delete();
    expB.delete();
    expRes.delete();
    expErr.delete();
    repeat (3) @(posedge clk);
    coreLat = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("postRstValid", out_valid, 0);
    checkOutput("postRstResults", resultLog.size(), 0);
    applyStimulus(32'd42642, 32'd44145);
    measureLatency(lat);
    checkOutput("postRstLat", lat, 7);
    waitDrain("drainPostRst");
    if (resultLog.size() == 1) checkOutput("postRstRes9", resultLog[0], 9);
    else checkOutput("postRstCount", resultLog.size(), 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
